// File: rtl/bch_wrapper_encoder_mem.sv
// Systematic BCH/CRC-style parity encoder: serially divides the message by the
// generator polynomial, then writes the parity to memory as W-bit words.
module bch_wrapper_encoder_mem #(
  parameter int unsigned                 C_I_DATABITS    = 4,
  parameter int unsigned                 C_ECC_BITS      = 3,
  parameter logic [C_ECC_BITS-1:0]       C_GEN_POLY      = 3'b011,
  parameter int unsigned                 C_MEM_ADDR_SIZE = 10,
  parameter int unsigned                 C_MEM_DATA_SIZE = 8,
  parameter int unsigned                 C_MEM_ST_ADDR   = 0
) (
  input  logic                       I_clk,
  input  logic                       I_rst_n,
  input  logic                       I_en,
  input  logic                       I_start,
  input  logic [C_I_DATABITS-1:0]    I_data,
  output logic [C_MEM_ADDR_SIZE-1:0] O_mem_addr,
  output logic [C_MEM_DATA_SIZE-1:0] O_mem_data,
  output logic                       O_mem_we,
  output logic                       O_busy,
  output logic                       O_done
);

  localparam int unsigned LP_MEM_WORDS = C_ECC_BITS / C_MEM_DATA_SIZE + 1;
  localparam int unsigned LP_PEXT_W    = LP_MEM_WORDS * C_MEM_DATA_SIZE;
  localparam int unsigned LP_CNT_MAX   = (C_I_DATABITS > LP_MEM_WORDS) ? C_I_DATABITS : LP_MEM_WORDS;
  localparam int unsigned LP_CNT_W     = $clog2(LP_CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ENC, WRITE, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       start_q, start_d;
  logic                       arm_q, arm_d;
  logic [C_I_DATABITS-1:0]    sr_q, sr_d;
  logic [C_ECC_BITS-1:0]      p_q, p_d;
  logic [LP_CNT_W-1:0]        cnt_q, cnt_d;
  logic [C_MEM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [C_MEM_DATA_SIZE-1:0] data_q, data_d;
  logic                       we_q, we_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       start_det;
  logic                       fb;
  logic [LP_PEXT_W-1:0]       p_ext;
  logic [C_MEM_DATA_SIZE-1:0] word;

  // arm_q blocks a start until I_start has been seen low, so a level held
  // high across reset release or re-enable never looks like a fresh edge.
  assign start_det = arm_q & ~start_q & I_start & I_en;
  assign fb        = sr_q[C_I_DATABITS-1] ^ p_q[C_ECC_BITS-1];
  assign p_ext     = LP_PEXT_W'(p_q);

  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < LP_MEM_WORDS; k++) begin
      if (cnt_q == LP_CNT_W'(k)) word = p_ext[k*C_MEM_DATA_SIZE +: C_MEM_DATA_SIZE];
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = I_start;
    arm_d   = arm_q | ~I_start;
    sr_d    = sr_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    data_d  = '0;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_det) begin
          sr_d    = I_data;
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ENC;
        end
      end
      ENC: begin
        sr_d  = sr_q << 1;
        p_d   = (p_q << 1) ^ (fb ? C_GEN_POLY : '0);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LP_CNT_W'(C_I_DATABITS - 1)) begin
          cnt_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q < LP_CNT_W'(LP_MEM_WORDS)) begin
          we_d   = 1'b1;
          addr_d = C_MEM_ADDR_SIZE'(C_MEM_ST_ADDR) + C_MEM_ADDR_SIZE'(cnt_q);
          data_d = word;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!I_en) begin
      state_d = IDLE;
      start_d = 1'b0;
      arm_d   = ~I_start;
      cnt_d   = '0;
      addr_d  = '0;
      data_d  = '0;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      sr_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      arm_q   <= arm_d;
      sr_q    <= sr_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O_mem_addr = addr_q;
  assign O_mem_data = data_q;
  assign O_mem_we   = we_q;
  assign O_busy     = busy_q;
  assign O_done     = done_q;

endmodule

// File: tb/tb_bch_wrapper_encoder_mem.sv
// Directed bench for bch_wrapper_encoder_mem with R=3, g=x^3+x+1, W=2 (two parity words).
module tb_bch_wrapper_encoder_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [3:0] data;
  logic [9:0] mem_addr;
  logic [1:0] mem_data;
  logic       mem_we;
  logic       busy;
  logic       done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bch_wrapper_encoder_mem #(
    .C_I_DATABITS   (4),
    .C_ECC_BITS     (3),
    .C_GEN_POLY     (3'b011),
    .C_MEM_ADDR_SIZE(10),
    .C_MEM_DATA_SIZE(2),
    .C_MEM_ST_ADDR  (0)
  ) dut (
    .I_clk     (clk),
    .I_rst_n   (rst_n),
    .I_en      (en),
    .I_start   (start),
    .I_data    (data),
    .O_mem_addr(mem_addr),
    .O_mem_data(mem_data),
    .O_mem_we  (mem_we),
    .O_busy    (busy),
    .O_done    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sample j is taken on the falling edge after capture edge c+j.
  task automatic run_enc(input string name, input logic [3:0] d, input logic [1:0] w0,
                         input logic [1:0] w1, input bit reedge);
    int nwe = 0;
    int ndone = 0;
    @(negedge clk) start = 1'b0;
    @(negedge clk) begin start = 1'b1; data = d; end
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (done) ndone++;
      case (j)
        1: check({name, " busy@1"}, busy, 1);
        4: check({name, " we@4"}, mem_we, 0);
        5: begin
          check({name, " we@5"}, mem_we, 1);
          check({name, " addr0"}, mem_addr, 0);
          check({name, " word0"}, mem_data, w0);
        end
        6: begin
          check({name, " we@6"}, mem_we, 1);
          check({name, " addr1"}, mem_addr, 1);
          check({name, " word1"}, mem_data, w1);
          check({name, " done@6"}, done, 0);
        end
        7: begin
          check({name, " we@7"}, mem_we, 0);
          check({name, " done@7"}, done, 1);
          check({name, " idle addr"}, mem_addr, 0);
          check({name, " idle data"}, mem_data, 0);
        end
        8: begin
          check({name, " busy@8"}, busy, 0);
          check({name, " done@8"}, done, 0);
        end
        default: ;
      endcase
      if (j == 0) data = ~d;
      if (reedge && j == 4) start = 1'b0;
      if (reedge && j == 5) start = 1'b1;
    end
    check({name, " write count"}, nwe, 2);
    check({name, " done count"}, ndone, 1);
    check({name, " busy end"}, busy, 0);
  endtask

  initial begin
    int nbusy;
    int nwe;
    int ndone;
    rst_n = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    data  = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset we", mem_we, 0);
    check("reset done", done, 0);
    check("reset addr", mem_addr, 0);
    check("reset data", mem_data, 0);
    @(negedge clk) rst_n = 1'b1;

    run_enc("d1000", 4'b1000, 2'b01, 2'b01, 1'b0);
    run_enc("d0001", 4'b0001, 2'b11, 2'b00, 1'b0);
    run_enc("d0000", 4'b0000, 2'b00, 2'b00, 1'b0);
    run_enc("d0100", 4'b0100, 2'b11, 2'b01, 1'b0);
    run_enc("d1011", 4'b1011, 2'b00, 2'b00, 1'b0);
    run_enc("reedge", 4'b1000, 2'b01, 2'b01, 1'b1);

    // Start still held high from the last run: must not retrigger.
    nbusy = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    check("held start no rerun", nbusy, 0);

    // Enable dropped mid-ENC.
    @(negedge clk) start = 1'b0;
    @(negedge clk) begin start = 1'b1; data = 4'b1000; end
    @(negedge clk);
    @(negedge clk);
    check("en busy before drop", busy, 1);
    en = 1'b0;
    @(negedge clk);
    check("en drop busy", busy, 0);
    nwe = 0;
    ndone = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (done) ndone++;
    end
    check("en drop writes", nwe, 0);
    check("en drop done", ndone, 0);
    en = 1'b1;
    run_enc("after en", 4'b0001, 2'b11, 2'b00, 1'b0);

    // Asynchronous reset in the middle of WRITE.
    @(negedge clk) start = 1'b0;
    @(negedge clk) begin start = 1'b1; data = 4'b1000; end
    for (int j = 0; j < 6; j++) @(negedge clk);
    check("pre-reset we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst we", mem_we, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst addr", mem_addr, 0);
    check("async rst data", mem_data, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    nbusy = 0;
    nwe = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (mem_we) nwe++;
    end
    check("post-reset no start", nbusy, 0);
    check("post-reset no write", nwe, 0);
    run_enc("after rst", 4'b0100, 2'b11, 2'b01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
